fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the architectural PC register and sequences instruction fetch for the rv32i core.
//  Issues one instruction-memory request at a time and hands each fetched word to decode via valid/ready.
//  Accepts redirects (taken branch/jump new_pc from execute), squashing any in-flight or held fetch.
//  Sits between the imem port and decode; the PC-select logic feeds its redirect inputs.
// PARAMETERS
//  RESET_PC   32'h0000_0000   first fetch address after reset
//  XLEN       32              address/data width; only 32 is supported
// PORTS
//  clk             in   1     single clock; all state updates on posedge
//  rst             in   1     synchronous, active-high reset
//  imem_req        out  1     fetch request; held until imem_gnt
//  imem_addr       out  32    fetch address; stable while imem_req && !imem_gnt
//  imem_gnt        in   1     request accepted this cycle
//  imem_rvalid     in   1     read data valid; >=1 cycle after gnt, exactly one per gnt
//  imem_rdata      in   32    instruction word
//  if_valid        out  1     fetched instruction held for decode
//  if_ready        in   1     decode accepts; handshake = if_valid && if_ready
//  if_instr        out  32    instruction word
//  if_pc           out  32    address of if_instr
//  if_pc_plus_4    out  32    if_pc + 4 (mod 2^32)
//  redirect_valid  in   1     taken branch/jump this cycle
//  redirect_pc     in   32    redirect target
//  misalign_err    out  1     1-cycle pulse: redirect_pc[1:0] != 0
//  fetch_count     out  32    count of completed decode handshakes, wraps at 2^32
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC,
//   if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc_plus_4=RESET_PC+4, misalign_err=0, fetch_count=0.
//   Reset overrides everything, including mid-transaction; stale imem_rvalid after reset is ignored in IDLE.
//  States: IDLE, REQ, WAIT, HOLD. All outputs registered.
//  IDLE: next cycle -> REQ (first request is asserted 2 cycles after rst deasserts).
//  REQ: imem_req=1, imem_addr=pc. gnt -> WAIT.
//  WAIT: imem_req=0. rvalid && !kill -> latch if_instr=rdata, if_pc=pc, if_pc_plus_4=pc+4,
//   if_valid=1, pc<=pc+4, -> HOLD. rvalid && kill -> discard word, kill<=0, -> REQ.
//  HOLD: if_valid=1, outputs stable. if_ready -> if_valid<=0, fetch_count++, -> REQ.
//  Redirect (highest priority, any non-IDLE state): pc<=redirect_pc & ~32'h3; misalign_err<=|redirect_pc[1:0].
//   REQ, no gnt: imem_addr held (bus rule); kill<=1; stay REQ. Granted word then returns and is discarded.
//   REQ with gnt same cycle: kill<=1, -> WAIT.
//   WAIT, no rvalid: kill<=1. WAIT with rvalid same cycle: word discarded, kill<=0, -> REQ.
//   HOLD: if_valid<=0, -> REQ. If if_ready same cycle, handshake counts (fetch_count++).
//  Redirect in IDLE is ignored. Back-to-back redirects: the last target wins; kill stays set.
//  pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently. Only one request is outstanding.
//  Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD) with gnt immediate, rvalid +1, ready=1.
// STRUCTURE
//  Package fetch_pkg: fetch_state_e enum {IDLE,REQ,WAIT,HOLD}, localparam PC_ALIGN_MASK=32'hFFFF_FFFC.
//  Single flat module: state reg, pc reg, kill flag, output buffer, counter. No sub-module.
// TESTING
//  1. rst 2 cycles, gnt immediate, rvalid 1 cycle later, ready=1 -> addrs 0,4,8 fetched; if_pc 0,4,8; fetch_count=3.
//  2. ready=0 for 5 cycles in HOLD -> if_instr/if_pc stable, imem_req=0, no new request until ready.
//  3. Redirect to 32'h100 during WAIT (rvalid 2 cycles later) -> word discarded, next imem_addr=32'h100, if_pc=32'h100.
//  4. Redirect to 32'h200 in REQ, gnt delayed 3 cycles -> imem_addr stays old until gnt; response dropped; next req at 32'h200.
//  5. Redirect to 32'h103 in HOLD with ready=1 -> fetch_count+1, misalign_err pulse, next imem_addr=32'h100.
//  6. rst asserted in WAIT, rvalid arrives during reset -> outputs at reset values; fetch restarts at RESET_PC; no if_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the rv32i instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and sequences one-at-a-time instruction fetches,
// handing each fetched word to decode over a valid/ready handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus_4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            redirect;

  logic            imem_req_d;
  logic [XLEN-1:0] imem_addr_d;
  logic            if_valid_d;
  logic [XLEN-1:0] if_instr_d;
  logic [XLEN-1:0] if_pc_d;
  logic [XLEN-1:0] if_pc_plus_4_d;
  logic            misalign_err_d;
  logic [31:0]     fetch_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= RESET_PC;
      if_pc_plus_4 <= RESET_PC + PC_STEP;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      imem_req     <= imem_req_d;
      imem_addr    <= imem_addr_d;
      if_valid     <= if_valid_d;
      if_instr     <= if_instr_d;
      if_pc        <= if_pc_d;
      if_pc_plus_4 <= if_pc_plus_4_d;
      misalign_err <= misalign_err_d;
      fetch_count  <= fetch_count_d;
    end
  end

  // Redirects outrank every other event but are meaningless before the first request.
  assign redirect = redirect_valid && (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    kill_d         = kill_q;
    if_valid_d     = if_valid;
    if_instr_d     = if_instr;
    if_pc_d        = if_pc;
    if_pc_plus_4_d = if_pc_plus_4;
    misalign_err_d = 1'b0;
    fetch_count_d  = fetch_count;

    if (redirect) begin
      pc_d           = redirect_pc & PC_ALIGN_MASK;
      misalign_err_d = |redirect_pc[1:0];
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // The bus forbids changing the address mid-request, so a redirect only marks the word stale.
        if (redirect) kill_d = 1'b1;
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid && (kill_q || redirect)) begin
          kill_d  = 1'b0;
          state_d = REQ;
        end else if (imem_rvalid) begin
          if_valid_d     = 1'b1;
          if_instr_d     = imem_rdata;
          if_pc_d        = pc_q;
          if_pc_plus_4_d = pc_q + PC_STEP;
          pc_d           = pc_q + PC_STEP;
          state_d        = HOLD;
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (if_ready) fetch_count_d = fetch_count + 32'd1;
        if (if_ready || redirect) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    imem_req_d  = (state_d == REQ);
    imem_addr_d = ((state_d == REQ) && (state_q != REQ)) ? pc_d : imem_addr;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector table plus randomized traffic checked against a stream-level
// model of the expected instruction sequence for fetch_sequencer.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  fetch_sequencer #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus_4  (if_pc_plus_4),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        rdv;
    logic [31:0] rdpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic        e_mis;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic rdv, input logic [31:0] rdpc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic [31:0] e_cnt, input logic e_mis);
    vec_t v;
    v.rst = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.rdv = rdv; v.rdpc = rdpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_mis = e_mis;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive one vector ahead of a rising edge, then check the registered outputs mid-cycle.
  task automatic apply_stimulus(input vec_t v, input string tag);
    rst            = v.rst;
    imem_gnt       = v.gnt;
    imem_rvalid    = v.rvalid;
    imem_rdata     = v.rdata;
    if_ready       = v.ready;
    redirect_valid = v.rdv;
    redirect_pc    = v.rdpc;
    @(posedge clk);
    @(negedge clk);
    check_bit   ({tag, ".req"},   imem_req,     v.e_req);
    check_output({tag, ".addr"},  imem_addr,    v.e_addr);
    check_bit   ({tag, ".valid"}, if_valid,     v.e_valid);
    check_output({tag, ".count"}, fetch_count,  v.e_cnt);
    check_bit   ({tag, ".mis"},   misalign_err, v.e_mis);
    if (v.e_valid || v.rst) begin
      check_output({tag, ".instr"}, if_instr,     v.e_instr);
      check_output({tag, ".pc"},    if_pc,        v.e_pc);
      check_output({tag, ".pc4"},   if_pc_plus_4, v.e_pc + 32'd4);
    end
  endtask

  logic [31:0] exp_pc;
  logic [31:0] tgt;
  logic [31:0] prev_addr;
  logic [31:0] out_addr;
  int          hs_cnt;
  int          out_cnt;
  int          quiet;
  int          stall;
  bit          out_busy;
  bit          mis_pend;
  bit          prev_req;
  bit          prev_gnt;
  bit          prev_rst;

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset, three straight-line fetches, a five-cycle decode stall, then a misaligned redirect in REQ.
    vecs.push_back(mk(1,0,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,0,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0,32'h0,         1,32'h0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,32'hC0DE0000,0,0,32'h0,  0,32'h0,1,32'hC0DE0000,32'h0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,1,0,32'h0,         1,32'h4,0,32'h0,32'h0,1,0));
    vecs.push_back(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h4,0,32'h0,32'h0,1,0));
    vecs.push_back(mk(0,0,1,32'hC0DE0004,0,0,32'h0,  0,32'h4,1,32'hC0DE0004,32'h4,1,0));
    vecs.push_back(mk(0,0,0,32'h0,1,0,32'h0,         1,32'h8,0,32'h0,32'h0,2,0));
    vecs.push_back(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h8,0,32'h0,32'h0,2,0));
    vecs.push_back(mk(0,0,1,32'hC0DE0008,0,0,32'h0,  0,32'h8,1,32'hC0DE0008,32'h8,2,0));
    vecs.push_back(mk(0,0,0,32'h0,1,0,32'h0,         1,32'hC,0,32'h0,32'h0,3,0));
    vecs.push_back(mk(0,1,0,32'h0,0,0,32'h0,         0,32'hC,0,32'h0,32'h0,3,0));
    vecs.push_back(mk(0,0,1,32'hC0DE000C,0,0,32'h0,  0,32'hC,1,32'hC0DE000C,32'hC,3,0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,0,32'h0,0,0,32'h0,       0,32'hC,1,32'hC0DE000C,32'hC,3,0));
    vecs.push_back(mk(0,0,0,32'h0,1,0,32'h0,         1,32'h10,0,32'h0,32'h0,4,0));
    vecs.push_back(mk(0,0,0,32'h0,0,1,32'h103,       1,32'h10,0,32'h0,32'h0,4,1));
    vecs.push_back(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h10,0,32'h0,32'h0,4,0));
    vecs.push_back(mk(0,0,1,32'hDEADBEEF,0,0,32'h0,  1,32'h100,0,32'h0,32'h0,4,0));
    vecs.push_back(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h100,0,32'h0,32'h0,4,0));
    vecs.push_back(mk(0,0,1,32'hC0DE0100,0,0,32'h0,  0,32'h100,1,32'hC0DE0100,32'h100,4,0));
    vecs.push_back(mk(0,0,0,32'h0,1,0,32'h0,         1,32'h104,0,32'h0,32'h0,5,0));

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Redirect to 0x100 while waiting; the response two cycles later is dropped.
    apply_stimulus(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h104,0,32'h0,32'h0,5,0), "wait_redir.gnt");
    apply_stimulus(mk(0,0,0,32'h0,0,1,32'h100,       0,32'h104,0,32'h0,32'h0,5,0), "wait_redir.hit");
    apply_stimulus(mk(0,0,0,32'h0,0,0,32'h0,         0,32'h104,0,32'h0,32'h0,5,0), "wait_redir.idle");
    apply_stimulus(mk(0,0,1,32'hBAD0BAD0,0,0,32'h0,  1,32'h100,0,32'h0,32'h0,5,0), "wait_redir.drop");
    apply_stimulus(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h100,0,32'h0,32'h0,5,0), "wait_redir.gnt2");
    apply_stimulus(mk(0,0,1,32'hC0DE0100,0,0,32'h0,  0,32'h100,1,32'hC0DE0100,32'h100,5,0), "wait_redir.data");

    // Misaligned redirect in HOLD while decode accepts: handshake still counts.
    apply_stimulus(mk(0,0,0,32'h0,1,1,32'h103,       1,32'h100,0,32'h0,32'h0,6,1), "hold_redir");

    // Redirect in REQ with the grant delayed three cycles.
    apply_stimulus(mk(0,0,0,32'h0,0,1,32'h200,       1,32'h100,0,32'h0,32'h0,6,0), "req_redir.hit");
    apply_stimulus(mk(0,0,0,32'h0,0,0,32'h0,         1,32'h100,0,32'h0,32'h0,6,0), "req_redir.w1");
    apply_stimulus(mk(0,0,0,32'h0,0,0,32'h0,         1,32'h100,0,32'h0,32'h0,6,0), "req_redir.w2");
    apply_stimulus(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h100,0,32'h0,32'h0,6,0), "req_redir.gnt");
    apply_stimulus(mk(0,0,1,32'hBAD1BAD1,0,0,32'h0,  1,32'h200,0,32'h0,32'h0,6,0), "req_redir.drop");

    // Reset while waiting, with the stale response landing during and after reset.
    apply_stimulus(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h200,0,32'h0,32'h0,6,0), "rst_wait.gnt");
    apply_stimulus(mk(1,0,1,32'hBAD2BAD2,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0,0), "rst_wait.rst");
    apply_stimulus(mk(0,0,1,32'hBAD3BAD3,0,0,32'h0,  1,32'h0,0,32'h0,32'h0,0,0), "rst_wait.stale");
    apply_stimulus(mk(0,1,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h0,32'h0,0,0), "rst_wait.gnt2");
    apply_stimulus(mk(0,0,1,32'hC0DE0000,0,0,32'h0,  0,32'h0,1,32'hC0DE0000,32'h0,0,0), "rst_wait.data");
    apply_stimulus(mk(0,0,0,32'h0,1,0,32'h0,         1,32'h4,0,32'h0,32'h0,1,0), "rst_wait.hs");

    // Randomized traffic: the model tracks only which PC decode must see next.
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_pc = RST_PC; hs_cnt = 0; out_busy = 1'b0; out_cnt = 0; out_addr = '0;
    quiet = 2; stall = 0; mis_pend = 1'b0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_rst = 1'b1; prev_addr = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (prev_rst) begin
        check_bit("rnd.rst_valid", if_valid, 1'b0);
        check_bit("rnd.rst_req", imem_req, 1'b0);
      end
      check_output("rnd.fetch_count", fetch_count, 32'(hs_cnt));
      check_bit("rnd.misalign", misalign_err, mis_pend);
      if (!prev_rst && imem_req && prev_req && !prev_gnt)
        check_output("rnd.addr_stable", imem_addr, prev_addr);
      if (out_busy)
        check_bit("rnd.single_outstanding", imem_req, 1'b0);

      prev_rst  = 1'b0;
      prev_req  = imem_req;
      prev_addr = imem_addr;
      mis_pend  = 1'b0;
      stall++;

      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
        exp_pc = RST_PC; hs_cnt = 0; out_busy = 1'b0; quiet = 2; stall = 0; prev_rst = 1'b1;
      end else begin
        rst = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (out_busy) begin
          out_cnt--;
          if (out_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(out_addr);
            out_busy    = 1'b0;
          end
        end
        imem_gnt = 1'b0;
        if (imem_req && !out_busy && ($urandom_range(0, 9) < 6)) begin
          imem_gnt = 1'b1;
          out_busy = 1'b1;
          out_cnt  = $urandom_range(1, 3);
          out_addr = imem_addr;
        end
        if_ready = 1'($urandom_range(0, 1));
        redirect_valid = 1'b0;
        if (quiet > 0) quiet--;
        else redirect_valid = ($urandom_range(0, 11) == 0);
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
        redirect_pc = tgt;

        if (if_valid && if_ready) begin
          check_output("rnd.hs_pc", if_pc, exp_pc);
          check_output("rnd.hs_instr", if_instr, mem_word(exp_pc));
          check_output("rnd.hs_pc4", if_pc_plus_4, exp_pc + 32'd4);
          hs_cnt++;
          exp_pc = exp_pc + 32'd4;
          stall  = 0;
        end
        if (redirect_valid) begin
          exp_pc   = tgt & 32'hFFFF_FFFC;
          mis_pend = |tgt[1:0];
        end
      end
      prev_gnt = imem_gnt;

      if (stall > 300) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL rnd.progress: %0d cycles without a handshake, limit 300", stall);
        stall = 0;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
